// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: widths, bubble encoding, fetch entry
// struct and small arithmetic helpers used by the fetch stage.
package cpu_pkg;

    localparam int PC_W   = 32;
    localparam int INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_FIFO   = 2'd2,
        IFID_BYPASS = 2'd3
    } ifid_sel_e;

    // Sequential fetch address; wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Saturating event counter step.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        logic [31:0] res;
        if (en && (val != 32'hFFFF_FFFF)) begin
            res = val + 32'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of hazard-control inputs, instruction-memory bus and IF/ID outputs of the fetch stage.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              branch_taken;
    logic [PC_W-1:0]   branch_target;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [INSN_W-1:0] imem_rdata;
    logic [PC_W-1:0]   ifid_pc;
    logic [INSN_W-1:0] ifid_insn;
    logic              ifid_valid;
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;

    modport master (
        input  pc_write, ifid_write, ifid_flush, branch_taken, branch_target, imem_rdata,
        output imem_req, imem_addr, ifid_pc, ifid_insn, ifid_valid, stall_cnt, flush_cnt
    );

    modport slave (
        output pc_write, ifid_write, ifid_flush, branch_taken, branch_target, imem_rdata,
        input  imem_req, imem_addr, ifid_pc, ifid_insn, ifid_valid, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer of returned fetch words; supports simultaneous push and pop
// when full, with clear taking priority over both.
module fetch_skid_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   cnt_r;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else if (clear) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            cnt_r <= cnt_r + {1'b0, push} - {1'b0, pop};
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = cnt_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, 1-cycle IMEM request tracking, skid FIFO and IF/ID register.
// Optional saturating stall/flush counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [cpu_pkg::PC_W-1:0]   RESET_PC = 32'h0000_0000,
    parameter logic [cpu_pkg::INSN_W-1:0] NOP_INSN = cpu_pkg::NOP_INSN
) (
    input logic            clk,
    input logic            rst,
    fetch_stage_if.master  bus
);
    import cpu_pkg::*;

    logic [PC_W-1:0]   pc_r;
    logic              pend_r;
    logic [PC_W-1:0]   pend_pc_r;
    logic              pend_kill_r;
    logic [PC_W-1:0]   ifid_pc_r;
    logic [INSN_W-1:0] ifid_insn_r;
    logic              ifid_valid_r;

    logic [1:0]        fifo_cnt_s;
    fetch_entry_t      fifo_head_s;
    fetch_entry_t      ret_entry_s;
    logic              ret_valid_s;
    logic              fifo_empty_s;
    logic              src_avail_s;
    logic              pop_s;
    logic [2:0]        inflight_s;
    logic              issue_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    ifid_sel_e         ifid_sel_s;

    // Issue/return decisions; occupancy counts the pending word even if killed.
    always_comb begin
        ret_valid_s  = pend_r & ~pend_kill_r;
        ret_entry_s  = '{pc: pend_pc_r, insn: bus.imem_rdata};
        fifo_empty_s = (fifo_cnt_s == 2'd0);
        src_avail_s  = ~fifo_empty_s | ret_valid_s;
        pop_s        = bus.ifid_write & src_avail_s;
        inflight_s   = {1'b0, fifo_cnt_s} + {2'b00, pend_r} - {2'b00, pop_s};
        issue_s      = ~rst & bus.pc_write & ~bus.ifid_flush & (inflight_s < 3'd2);
        fifo_push_s  = ret_valid_s & ~bus.ifid_flush & ~(fifo_empty_s & bus.ifid_write);
        fifo_pop_s   = bus.ifid_write & ~bus.ifid_flush & ~fifo_empty_s;
    end

    // IF/ID source select: flush beats stall, FIFO head beats the bypass word.
    always_comb begin
        ifid_sel_s = IFID_HOLD;
        if (bus.ifid_flush) begin
            ifid_sel_s = IFID_BUBBLE;
        end else if (!bus.ifid_write) begin
            ifid_sel_s = IFID_HOLD;
        end else if (!fifo_empty_s) begin
            ifid_sel_s = IFID_FIFO;
        end else if (ret_valid_s) begin
            ifid_sel_s = IFID_BYPASS;
        end else begin
            ifid_sel_s = IFID_BUBBLE;
        end
    end

    fetch_skid_fifo u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.ifid_flush),
        .push      (fifo_push_s),
        .push_data (ret_entry_s),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .count     (fifo_cnt_s)
    );

    // Program counter; a taken redirect only applies together with a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (bus.ifid_flush && bus.branch_taken) begin
            pc_r <= bus.branch_target;
        end else if (issue_s) begin
            pc_r <= next_pc(pc_r);
        end else begin
            pc_r <= pc_r;
        end
    end

    // In-flight request tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r      <= 1'b0;
            pend_pc_r   <= '0;
            pend_kill_r <= 1'b0;
        end else begin
            pend_r <= issue_s;
            if (issue_s) begin
                pend_pc_r <= pc_r;
            end
            if (bus.ifid_flush) begin
                pend_kill_r <= pend_r;
            end else if (issue_s) begin
                pend_kill_r <= 1'b0;
            end
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_pc_r    <= '0;
            ifid_insn_r  <= NOP_INSN;
            ifid_valid_r <= 1'b0;
        end else begin
            case (ifid_sel_s)
                IFID_FIFO: begin
                    ifid_pc_r    <= fifo_head_s.pc;
                    ifid_insn_r  <= fifo_head_s.insn;
                    ifid_valid_r <= 1'b1;
                end
                IFID_BYPASS: begin
                    ifid_pc_r    <= ret_entry_s.pc;
                    ifid_insn_r  <= ret_entry_s.insn;
                    ifid_valid_r <= 1'b1;
                end
                IFID_BUBBLE: begin
                    ifid_pc_r    <= '0;
                    ifid_insn_r  <= NOP_INSN;
                    ifid_valid_r <= 1'b0;
                end
                default: begin
                    ifid_pc_r    <= ifid_pc_r;
                    ifid_insn_r  <= ifid_insn_r;
                    ifid_valid_r <= ifid_valid_r;
                end
            endcase
        end
    end

    assign bus.imem_req   = issue_s;
    assign bus.imem_addr  = pc_r;
    assign bus.ifid_pc    = ifid_pc_r;
    assign bus.ifid_insn  = ifid_insn_r;
    assign bus.ifid_valid = ifid_valid_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'h0;
            flush_cnt_r <= 32'h0;
        end else begin
            stall_cnt_r <= sat_inc(stall_cnt_r, ~bus.ifid_write & ~bus.ifid_flush);
            flush_cnt_r <= sat_inc(flush_cnt_r, bus.ifid_flush);
        end
    end

    assign bus.stall_cnt = stall_cnt_r;
    assign bus.flush_cnt = flush_cnt_r;
`else
    assign bus.stall_cnt = 32'h0;
    assign bus.flush_cnt = 32'h0;
`endif

endmodule
